// File: rtl/nes_pkg.sv
// Constants and types shared by the NES controller reader (Pong) and the
// console-side responder.
package nes_pkg;

    localparam int NES_BTN_A      = 0;
    localparam int NES_BTN_B      = 1;
    localparam int NES_BTN_SELECT = 2;
    localparam int NES_BTN_START  = 3;
    localparam int NES_BTN_UP     = 4;
    localparam int NES_BTN_DOWN   = 5;
    localparam int NES_BTN_LEFT   = 6;
    localparam int NES_BTN_RIGHT  = 7;

    localparam int NES_FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_e;

    typedef struct packed {
        logic nes_data;
        logic busy;
        logic frame_done;
    } nes_out_t;

endpackage

// File: rtl/nes_input_sync.sv
// Multi-flop synchronizer for an asynchronous pin plus a rising-edge detector
// taken from the last stage and one extra registered copy.
module nes_input_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise
);
    // Depth below 2 gives no metastability protection, so clamp it.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
            prev_q <= sync_q[N-1];
        end
    end

    assign level = sync_q[N-1];
    assign rise  = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/nes_controller_responder.sv
// Emulates the 4021 shift register inside an NES pad: latches the button
// state on the latch strobe and shifts it out, active-low, on the reader clock.
module nes_controller_responder
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nes_latch,
    input  logic       nes_clk,
    input  logic [7:0] buttons,
    output logic       nes_data,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] poll_count
);
    logic latch_lvl, latch_rise;
    logic clk_lvl, clk_rise;

    nes_input_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nes_latch),
        .level   (latch_lvl),
        .rise    (latch_rise)
    );

    nes_input_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nes_clk),
        .level   (clk_lvl),
        .rise    (clk_rise)
    );

    nes_state_e state, state_n;
    logic [7:0] shift_reg, shift_n;
    logic [3:0] bit_cnt, cnt_n;
    nes_out_t   out_q, out_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= 8'hFF;
            bit_cnt    <= '0;
            out_q      <= '{nes_data: 1'b1, busy: 1'b0, frame_done: 1'b0};
            poll_count <= '0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= cnt_n;
            out_q     <= out_n;
            if (latch_rise)
                poll_count <= poll_count + 8'd1;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
        out_n   = '{nes_data: 1'b1, busy: 1'b0, frame_done: 1'b0};

        // A latch edge aborts whatever is in flight and beats a same-cycle clock edge.
        if (latch_rise) begin
            state_n = LOAD;
            shift_n = ~buttons;
            cnt_n   = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (latch_lvl) begin
                        shift_n = ~buttons;
                        cnt_n   = '0;
                    end else begin
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        shift_n = {1'b0, shift_reg[7:1]};
                        cnt_n   = bit_cnt + 4'd1;
                        if (cnt_n == 4'(NES_FRAME_BITS)) begin
                            state_n          = DONE;
                            out_n.frame_done = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        out_n.busy = (state_n == LOAD) || (state_n == SHIFT);
        case (state_n)
            IDLE:    out_n.nes_data = 1'b1;
            DONE:    out_n.nes_data = 1'b0;
            default: out_n.nes_data = shift_n[NES_BTN_A];
        endcase
    end

    assign nes_data   = out_q.nes_data;
    assign busy       = out_q.busy;
    assign frame_done = out_q.frame_done;

    // The clock level is only needed for edge detection.
    logic unused_ok;
    assign unused_ok = clk_lvl;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Bench for nes_controller_responder: table-driven frames checked through an
// expected-bit queue, plus directed latency, abort, collision, reset and wrap sequences.
`timescale 1ns/1ps
module tb_nes_controller_responder;
    import nes_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       nes_latch = 1'b0;
    logic       nes_clk = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       nes_data, busy, frame_done;
    logic [7:0] poll_count;

    nes_controller_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .buttons    (buttons),
        .nes_data   (nes_data),
        .busy       (busy),
        .frame_done (frame_done),
        .poll_count (poll_count)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [7:0] pc_exp = 8'h00;
    logic exp_q[$];

    always @(negedge clk) if (frame_done) fd_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse(input int hi, input int lo);
        nes_latch = 1'b1;
        pc_exp    = pc_exp + 8'd1;
        step(hi);
        nes_latch = 1'b0;
        step(lo);
    endtask

    task automatic clk_pulse(input int half);
        nes_clk = 1'b1;
        step(half);
        nes_clk = 1'b0;
        step(half);
    endtask

    task automatic sb_check(input string nm);
        logic e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got empty scoreboard expected entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, nes_data, e);
        end
    endtask

    typedef struct {
        logic [7:0] btn;
        logic [7:0] seq;  // seq[k] = nes_data after k clock edges
    } vec_t;
    vec_t vecs[5];

    initial begin
        int fd0;
        vecs[0] = '{btn: 8'b0000_0001, seq: 8'b1111_1110};
        vecs[1] = '{btn: 8'b1000_0000, seq: 8'b0111_1111};
        vecs[2] = '{btn: 8'h00,        seq: 8'hFF};
        vecs[3] = '{btn: 8'hFF,        seq: 8'h00};
        vecs[4] = '{btn: 8'hA5,        seq: 8'h5A};

        step(3);
        chk("rst_data", nes_data, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_pc", poll_count, 8'h00);
        reset_n = 1'b1;
        step(2);

        // exact pin-to-output latency
        buttons   = 8'h01;
        nes_latch = 1'b1;
        pc_exp    = pc_exp + 8'd1;
        step(2);
        chk("lat_before", nes_data, 1'b1);
        chk("lat_busy_before", busy, 1'b0);
        step(1);
        chk("lat_after", nes_data, 1'b0);
        chk("lat_busy_after", busy, 1'b1);
        chk("lat_pc", poll_count, pc_exp);
        step(10);
        nes_latch = 1'b0;
        step(10);

        // table-driven frames: 12 us latch, 6 us clock period
        for (int i = 0; i < 5; i++) begin
            buttons = vecs[i].btn;
            fd0 = fd_cnt;
            latch_pulse(300, 10);
            for (int k = 0; k < NES_FRAME_BITS; k++) exp_q.push_back(vecs[i].seq[k]);
            exp_q.push_back(1'b0);
            sb_check($sformatf("v%0d_bit0", i));
            chk($sformatf("v%0d_busy_shift", i), busy, 1'b1);
            for (int k = 1; k <= NES_FRAME_BITS; k++) begin
                clk_pulse(75);
                sb_check($sformatf("v%0d_edge%0d", i, k));
            end
            chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
            chk($sformatf("v%0d_fd_once", i), fd_cnt - fd0, 1);
            chk($sformatf("v%0d_pc", i), poll_count, pc_exp);
        end
        fd0 = fd_cnt;
        clk_pulse(75);
        chk("done_ignore_data", nes_data, 1'b0);
        chk("done_ignore_fd", fd_cnt - fd0, 0);

        // live reload while latch is held
        buttons   = 8'b1000_0000;
        nes_latch = 1'b1;
        pc_exp    = pc_exp + 8'd1;
        step(5);
        chk("live_right", nes_data, 1'b1);
        chk("live_busy", busy, 1'b1);
        clk_pulse(3);
        chk("live_clk_ignored", nes_data, 1'b1);
        buttons = 8'h01;
        step(3);
        chk("live_a", nes_data, 1'b0);
        nes_latch = 1'b0;
        step(5);
        buttons = 8'h80;
        step(5);
        chk("live_hold0", nes_data, 1'b0);
        clk_pulse(10);
        chk("live_hold1", nes_data, 1'b1);

        // abort after 4 edges
        buttons = 8'h0F;
        latch_pulse(20, 10);
        for (int k = 0; k < 4; k++) clk_pulse(10);
        chk("abort_mid", nes_data, 1'b1);
        fd0 = fd_cnt;
        buttons = 8'h03;
        nes_latch = 1'b1;
        pc_exp    = pc_exp + 8'd1;
        step(4);
        chk("abort_data", nes_data, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_pc", poll_count, pc_exp);
        nes_latch = 1'b0;
        step(10);
        chk("abort_no_fd", fd_cnt - fd0, 0);

        // latch and clock edge in the same clk
        buttons = 8'h01;
        latch_pulse(20, 10);
        chk("coll_pre", nes_data, 1'b0);
        fd0 = fd_cnt;
        nes_latch = 1'b1;
        nes_clk   = 1'b1;
        pc_exp    = pc_exp + 8'd1;
        step(4);
        chk("coll_data", nes_data, 1'b0);
        nes_latch = 1'b0;
        nes_clk   = 1'b0;
        step(10);
        chk("coll_hold", nes_data, 1'b0);
        for (int k = 0; k < 7; k++) clk_pulse(10);
        chk("coll_busy7", busy, 1'b1);
        chk("coll_nofd7", fd_cnt - fd0, 0);
        clk_pulse(10);
        chk("coll_busy8", busy, 1'b0);
        chk("coll_fd8", fd_cnt - fd0, 1);

        // reset mid-frame
        buttons = 8'h01;
        latch_pulse(20, 10);
        for (int k = 0; k < 5; k++) clk_pulse(10);
        chk("prerst_busy", busy, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("rst_mid_data", nes_data, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_pc", poll_count, 8'h00);
        pc_exp = 8'h00;
        step(3);
        reset_n = 1'b1;
        step(3);
        fd0 = fd_cnt;
        for (int k = 0; k < 10; k++) begin
            clk_pulse(10);
            chk($sformatf("postrst_data%0d", k), nes_data, 1'b1);
        end
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_fd", fd_cnt - fd0, 0);

        // poll_count wrap
        for (int k = 0; k < 255; k++) latch_pulse(5, 5);
        chk("pc_255", poll_count, 8'hFF);
        latch_pulse(5, 5);
        chk("pc_wrap", poll_count, 8'h00);
        latch_pulse(5, 5);
        chk("pc_after_wrap", poll_count, pc_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
